// File: rtl/mic1_mem_pkg.sv
// mic1_mem_pkg: shared widths and request records for the MIC-1 memory initiator.
package mic1_mem_pkg;
   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
   } mem_req_a_t;
   typedef struct packed {
      logic              fetch;
      logic [WORD_W-1:0] addr;
   } mem_req_b_t;
endpackage

// File: rtl/mem_interface_ctrl_if.sv
// mem_interface_ctrl_if: dual-port main-memory bus (port A word R/W, port B byte fetch).
interface mem_interface_ctrl_if;
   import mic1_mem_pkg::*;
   logic              wen_A;
   logic              ren_A;
   logic [WORD_W-1:0] addr_A;
   logic [WORD_W-1:0] wdata_A;
   logic [WORD_W-1:0] rdata_A;
   logic              ren_B;
   logic [WORD_W-1:0] addr_B;
   logic [BYTE_W-1:0] rdata_B;
   modport master (output wen_A, ren_A, addr_A, wdata_A, ren_B, addr_B, input rdata_A, rdata_B);
   modport slave  (input wen_A, ren_A, addr_A, wdata_A, ren_B, addr_B, output rdata_A, rdata_B);
endinterface

// File: rtl/mem_interface_ctrl.sv
// mem_interface_ctrl: MIC-1 datapath memory initiator owning MAR/MDR/PC/MBR, issuing
// registered port-A/port-B requests with data usable two cycles after the strobe.
module mem_interface_ctrl
   import mic1_mem_pkg::*;
#(
   parameter int MEM_WORDS = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mar_we,
   input  logic [WORD_W-1:0] mar_in,
   input  logic              mdr_we,
   input  logic [WORD_W-1:0] mdr_in,
   input  logic              pc_we,
   input  logic [WORD_W-1:0] pc_in,
   input  logic              rd,
   input  logic              wr,
   input  logic              fetch,
   output logic [WORD_W-1:0] mar,
   output logic [WORD_W-1:0] mdr,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] mbru,
   output logic [WORD_W-1:0] mbrs,
   output logic              rd_busy,
   output logic              fetch_busy,
   output logic              proto_err,
   output logic              addr_err,
   mem_interface_ctrl_if.master mem
);
   logic [WORD_W-1:0] mar_q, mar_d, mdr_q, mdr_d, pc_q, pc_d, mdr_fwd;
   logic [BYTE_W-1:0] mbr_q, mbr_d;
   mem_req_a_t        req_a_q, req_a_d;
   mem_req_b_t        req_b_q, req_b_d;
   logic              proto_err_q, proto_err_d, addr_err_q, addr_err_d, addr_ok;
   // Requests see same-cycle register loads; a landing read overrides a CPU MDR load.
   always_comb begin
      mar_d       = mar_we ? mar_in : mar_q;
      pc_d        = pc_we ? pc_in : pc_q;
      mdr_fwd     = mdr_we ? mdr_in : mdr_q;
      addr_ok     = mar_d < WORD_W'(MEM_WORDS);
      req_a_d     = '{rd: rd & ~wr & addr_ok, wr: wr & addr_ok, addr: mar_d, wdata: mdr_fwd};
      req_b_d     = '{fetch: fetch, addr: pc_d};
      mdr_d       = req_a_q.rd ? mem.rdata_A : mdr_fwd;
      mbr_d       = req_b_q.fetch ? mem.rdata_B : mbr_q;
      proto_err_d = (rd & wr) | (mdr_we & req_a_q.rd);
      addr_err_d  = (rd | wr) & ~addr_ok;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mar_q       <= '0;
         mdr_q       <= '0;
         pc_q        <= '0;
         mbr_q       <= '0;
         req_a_q     <= '0;
         req_b_q     <= '0;
         proto_err_q <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         mar_q       <= mar_d;
         mdr_q       <= mdr_d;
         pc_q        <= pc_d;
         mbr_q       <= mbr_d;
         req_a_q     <= req_a_d;
         req_b_q     <= req_b_d;
         proto_err_q <= proto_err_d;
         addr_err_q  <= addr_err_d;
      end
   end
   assign mar         = mar_q;
   assign mdr         = mdr_q;
   assign pc          = pc_q;
   assign mbru        = {{(WORD_W-BYTE_W){1'b0}}, mbr_q};
   assign mbrs        = {{(WORD_W-BYTE_W){mbr_q[BYTE_W-1]}}, mbr_q};
   assign rd_busy     = req_a_q.rd & ~rst;
   assign fetch_busy  = req_b_q.fetch & ~rst;
   assign proto_err   = proto_err_q;
   assign addr_err    = addr_err_q;
   assign mem.wen_A   = req_a_q.wr & ~rst;
   assign mem.ren_A   = req_a_q.rd & ~rst;
   assign mem.addr_A  = req_a_q.addr;
   assign mem.wdata_A = req_a_q.wdata;
   assign mem.ren_B   = req_b_q.fetch & ~rst;
   assign mem.addr_B  = req_b_q.addr;
endmodule

// File: tb/tb_mem_interface_ctrl.sv
// tb_mem_interface_ctrl: directed checks of mem_interface_ctrl against a negedge dual-port memory.
module tb_mem_interface_ctrl;
   logic        clk = 1'b0;
   logic        rst, mar_we, mdr_we, pc_we, rd, wr, fetch;
   logic [31:0] mar_in, mdr_in, pc_in;
   logic [31:0] mar, mdr, pc, mbru, mbrs;
   logic        rd_busy, fetch_busy, proto_err, addr_err;
   logic [31:0] mem_arr [512];
   logic [31:0] word_b;
   int          n_chk = 0;
   int          n_fail = 0;

   mem_interface_ctrl_if bus ();

   mem_interface_ctrl #(.MEM_WORDS(512)) dut (
      .clk(clk), .rst(rst),
      .mar_we(mar_we), .mar_in(mar_in), .mdr_we(mdr_we), .mdr_in(mdr_in),
      .pc_we(pc_we), .pc_in(pc_in), .rd(rd), .wr(wr), .fetch(fetch),
      .mar(mar), .mdr(mdr), .pc(pc), .mbru(mbru), .mbrs(mbrs),
      .rd_busy(rd_busy), .fetch_busy(fetch_busy), .proto_err(proto_err), .addr_err(addr_err),
      .mem(bus)
   );

   always #5 clk = ~clk;

   // Negedge dual-port memory; port B selects the byte combinationally from addr_B.
   always @(negedge clk) begin
      if (bus.wen_A) mem_arr[bus.addr_A[8:0]] <= bus.wdata_A;
      if (bus.ren_A) bus.rdata_A <= mem_arr[bus.addr_A[8:0]];
      if (bus.ren_B) word_b <= mem_arr[bus.addr_B[10:2]];
   end
   assign bus.rdata_B = 8'(word_b >> (8 * bus.addr_B[1:0]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      {mar_we, mdr_we, pc_we, rd, wr, fetch} = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      mar_in = '0; mdr_in = '0; pc_in = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      n_chk++; if (mar !== 32'h0) begin n_fail++; $display("FAIL reset_mar: got %h want %h", mar, 32'h0); end
      n_chk++; if (mdr !== 32'h0) begin n_fail++; $display("FAIL reset_mdr: got %h want %h", mdr, 32'h0); end
      n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      n_chk++; if (mbrs !== 32'h0) begin n_fail++; $display("FAIL reset_mbrs: got %h want %h", mbrs, 32'h0); end
      n_chk++; if ({bus.ren_A, bus.wen_A, bus.ren_B, rd_busy, fetch_busy, proto_err, addr_err} !== 7'b0)
         begin n_fail++; $display("FAIL reset_flags: got %b want 0000000", {bus.ren_A, bus.wen_A, bus.ren_B, rd_busy, fetch_busy, proto_err, addr_err}); end
   endtask

   task automatic test_read();
      mar_we = 1'b1; mar_in = 32'd5; rd = 1'b1;
      tick();
      idle();
      n_chk++; if (bus.ren_A !== 1'b1) begin n_fail++; $display("FAIL read_ren: got %b want 1", bus.ren_A); end
      n_chk++; if (bus.addr_A !== 32'd5) begin n_fail++; $display("FAIL read_addr: got %h want %h", bus.addr_A, 32'd5); end
      n_chk++; if (rd_busy !== 1'b1) begin n_fail++; $display("FAIL read_busy_c1: got %b want 1", rd_busy); end
      tick();
      n_chk++; if (mdr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_mdr: got %h want %h", mdr, 32'hDEADBEEF); end
      n_chk++; if (rd_busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_c2: got %b want 0", rd_busy); end
      n_chk++; if (bus.ren_A !== 1'b0) begin n_fail++; $display("FAIL read_ren_c2: got %b want 0", bus.ren_A); end
   endtask

   task automatic test_write_read();
      mar_we = 1'b1; mar_in = 32'd7; mdr_we = 1'b1; mdr_in = 32'h12345678; wr = 1'b1;
      tick();
      idle();
      n_chk++; if (bus.wen_A !== 1'b1) begin n_fail++; $display("FAIL wr_wen: got %b want 1", bus.wen_A); end
      n_chk++; if (bus.addr_A !== 32'd7) begin n_fail++; $display("FAIL wr_addr: got %h want %h", bus.addr_A, 32'd7); end
      n_chk++; if (bus.wdata_A !== 32'h12345678) begin n_fail++; $display("FAIL wr_wdata: got %h want %h", bus.wdata_A, 32'h12345678); end
      rd = 1'b1; mdr_we = 1'b1; mdr_in = 32'h0;
      tick();
      idle();
      n_chk++; if ({bus.ren_A, bus.wen_A} !== 2'b10) begin n_fail++; $display("FAIL wr_rd_strobes: got %b want 10", {bus.ren_A, bus.wen_A}); end
      n_chk++; if (mdr !== 32'h0) begin n_fail++; $display("FAIL wr_mdr_cleared: got %h want %h", mdr, 32'h0); end
      tick();
      n_chk++; if (mdr !== 32'h12345678) begin n_fail++; $display("FAIL wr_readback: got %h want %h", mdr, 32'h12345678); end
   endtask

   task automatic test_back_to_back_fetch();
      logic [7:0] exp [4];
      exp[0] = 8'h02; exp[1] = 8'h01; exp[2] = 8'hFF; exp[3] = 8'h80;
      for (int i = 0; i < 6; i++) begin
         if (i >= 2) begin
            n_chk++; if (mbru !== {24'h0, exp[i-2]}) begin n_fail++; $display("FAIL fetch_mbru[%0d]: got %h want %h", i, mbru, {24'h0, exp[i-2]}); end
         end
         if (i == 1) begin
            n_chk++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy: got %b want 1", fetch_busy); end
         end
         if (i < 4) begin
            pc_we = 1'b1; pc_in = 32'd4 + 32'(i); fetch = 1'b1;
         end else idle();
         if (i < 5) tick();
      end
      n_chk++; if (mbrs !== 32'hFFFFFF80) begin n_fail++; $display("FAIL fetch_mbrs: got %h want %h", mbrs, 32'hFFFFFF80); end
      n_chk++; if (pc !== 32'd7) begin n_fail++; $display("FAIL fetch_pc: got %h want %h", pc, 32'd7); end
   endtask

   task automatic test_rd_wr_conflict();
      mar_we = 1'b1; mar_in = 32'd9; mdr_we = 1'b1; mdr_in = 32'hCAFEF00D; rd = 1'b1; wr = 1'b1;
      tick();
      idle();
      n_chk++; if ({bus.wen_A, bus.ren_A} !== 2'b10) begin n_fail++; $display("FAIL conflict_strobes: got %b want 10", {bus.wen_A, bus.ren_A}); end
      n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL conflict_proto: got %b want 1", proto_err); end
      tick();
      n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL conflict_proto_pulse: got %b want 0", proto_err); end
      n_chk++; if (mem_arr[9] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL conflict_memword: got %h want %h", mem_arr[9], 32'hCAFEF00D); end
      n_chk++; if (mdr !== 32'hCAFEF00D) begin n_fail++; $display("FAIL conflict_mdr: got %h want %h", mdr, 32'hCAFEF00D); end
   endtask

   task automatic test_mdr_conflict();
      mar_we = 1'b1; mar_in = 32'd5; rd = 1'b1;
      tick();
      idle();
      mdr_we = 1'b1; mdr_in = 32'h11111111;
      tick();
      idle();
      n_chk++; if (mdr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mdrwe_mdr: got %h want %h", mdr, 32'hDEADBEEF); end
      n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL mdrwe_proto: got %b want 1", proto_err); end
      tick();
      n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL mdrwe_proto_pulse: got %b want 0", proto_err); end
   endtask

   task automatic test_range();
      mar_we = 1'b1; mar_in = 32'd512; rd = 1'b1;
      tick();
      idle();
      n_chk++; if (bus.ren_A !== 1'b0) begin n_fail++; $display("FAIL range_ren: got %b want 0", bus.ren_A); end
      n_chk++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL range_err: got %b want 1", addr_err); end
      mar_we = 1'b1; mar_in = 32'd511; rd = 1'b1;
      tick();
      idle();
      n_chk++; if (mdr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL range_mdr_kept: got %h want %h", mdr, 32'hDEADBEEF); end
      n_chk++; if ({bus.ren_A, addr_err} !== 2'b10) begin n_fail++; $display("FAIL range_511: got %b want 10", {bus.ren_A, addr_err}); end
      tick();
      n_chk++; if (mdr !== 32'h000001FF) begin n_fail++; $display("FAIL range_511_mdr: got %h want %h", mdr, 32'h000001FF); end
   endtask

   task automatic test_reset_mid();
      mar_we = 1'b1; mar_in = 32'd5; rd = 1'b1;
      tick();
      idle();
      rst = 1'b1;
      #1;
      n_chk++; if ({bus.ren_A, rd_busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ren: got %b want 00", {bus.ren_A, rd_busy}); end
      tick();
      rst = 1'b0;
      n_chk++; if (mdr !== 32'h0) begin n_fail++; $display("FAIL rstmid_mdr: got %h want %h", mdr, 32'h0); end
      n_chk++; if ({mar, pc, mbru} !== 96'h0) begin n_fail++; $display("FAIL rstmid_regs: got %h want 0", {mar, pc, mbru}); end
      n_chk++; if ({bus.ren_A, bus.wen_A, bus.ren_B, proto_err, addr_err} !== 5'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b want 00000", {bus.ren_A, bus.wen_A, bus.ren_B, proto_err, addr_err}); end
      tick();
      n_chk++; if (mdr !== 32'h0) begin n_fail++; $display("FAIL rstmid_no_capture: got %h want %h", mdr, 32'h0); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem_arr[i] = 32'(i);
      mem_arr[1] = 32'h80FF0102;
      mem_arr[5] = 32'hDEADBEEF;
      mem_arr[9] = 32'hAAAA5555;
      word_b = '0;
      bus.rdata_A = '0;
      test_reset();
      test_read();
      test_write_read();
      test_back_to_back_fetch();
      test_rd_wr_conflict();
      test_mdr_conflict();
      test_range();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
